fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the front end: the canonical NOP encoding, the
// fetch FSM state type and a word-alignment helper.
package riscv_pkg;

  // addi x0, x0, 0 -- presented to decode whenever no instruction is buffered
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_DROP = 2'd2
  } fetch_state_e;

  // Clear the byte-offset bits of an address
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: circular head/tail pointers
// with an occupancy count. Flush is synchronous and overrides push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic [31:0] i_push_pc,
  input  logic [31:0] i_push_instr,
  input  logic        i_pop,
  output logic        o_empty,
  output logic        o_full,
  output logic [31:0] o_head_pc,
  output logic [31:0] o_head_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_COUNT);
  // A push at full is only legal when the head leaves in the same cycle
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;

  assign o_head_pc    = r_mem_pc[r_head];
  assign o_head_instr = r_mem_instr[r_head];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + PTR_ONE;
      if (w_do_pop)  r_head <= r_head + PTR_ONE;
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_ONE;
    end
  end

  // Entry storage carries no reset; occupancy alone says what is valid
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem_pc[r_tail]    <= i_push_pc;
      r_mem_instr[r_tail] <= i_push_instr;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one word-aligned request at a time to
// instruction memory and queues {pc, instr} pairs for decode.
//
// Handshakes: the memory request is a level held from issue until the cycle
// i_imem_ack is sampled high (address frozen meanwhile, at most one
// outstanding); decode consumes the head on any edge where o_instr_valid and
// i_instr_ready are both high. A redirect flushes the buffer and marks any
// outstanding response for discard.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  output logic         o_imem_req,
  output logic [31:0]  o_imem_addr,
  input  logic         i_imem_ack,
  input  logic [31:0]  i_imem_rdata,
  input  logic         i_redirect_valid,
  input  logic [31:0]  i_redirect_pc,
  output logic         o_instr_valid,
  output logic [31:0]  o_instr,
  output logic [31:0]  o_pc,
  output logic [31:0]  o_pc_four,
  input  logic         i_instr_ready,
  output fetch_state_e o_dbg_state
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_addr;
  logic [31:0]  w_target;
  logic         w_push;
  logic         w_pop;
  logic         w_empty;
  logic         w_full;
  logic [31:0]  w_head_pc;
  logic [31:0]  w_head_instr;

  assign w_target = word_align(i_redirect_pc);
  // Only a response to an untouched request is kept
  assign w_push   = (r_state == WAIT) && i_imem_ack && !i_redirect_valid;
  assign w_pop    = !w_empty && i_instr_ready;

  // Fetch FSM and PC: issue from IDLE when there is room, wait for the ack,
  // and remember in WAIT_DROP that the pending response is stale
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_redirect_valid) begin
            r_pc <= w_target;
          end else if (!w_full) begin
            r_addr  <= r_pc;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (i_redirect_valid) begin
            r_pc    <= w_target;
            r_state <= i_imem_ack ? IDLE : WAIT_DROP;
          end else if (i_imem_ack) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= IDLE;
          end
        end
        WAIT_DROP: begin
          if (i_redirect_valid) r_pc <= w_target;
          if (i_imem_ack) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_redirect_valid),
    .i_push       (w_push),
    .i_push_pc    (r_addr),
    .i_push_instr (i_imem_rdata),
    .i_pop        (w_pop),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  assign o_imem_req    = (r_state != IDLE);
  assign o_imem_addr   = r_addr;
  assign o_instr_valid = !w_empty;
  assign o_instr       = w_empty ? NOP   : w_head_instr;
  assign o_pc          = w_empty ? '0    : w_head_pc;
  assign o_pc_four     = w_empty ? '0    : w_head_pc + 32'd4;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized
// traffic, all checked against a program-order model of the fetch stream.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  // ---------------- clock / reset ----------------
  logic         i_clk = 1'b0;
  logic         i_reset = 1'b0;
  logic         o_imem_req;
  logic [31:0]  o_imem_addr;
  logic         i_imem_ack;
  logic [31:0]  i_imem_rdata;
  logic         i_redirect_valid = 1'b0;
  logic [31:0]  i_redirect_pc = 32'h0;
  logic         o_instr_valid;
  logic [31:0]  o_instr;
  logic [31:0]  o_pc;
  logic [31:0]  o_pc_four;
  logic         i_instr_ready = 1'b1;
  fetch_state_e o_dbg_state;

  always #5 i_clk = ~i_clk;

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .i_redirect_valid(i_redirect_valid),
    .i_redirect_pc   (i_redirect_pc),
    .o_instr_valid   (o_instr_valid),
    .o_instr         (o_instr),
    .o_pc            (o_pc),
    .o_pc_four       (o_pc_four),
    .i_instr_ready   (i_instr_ready),
    .o_dbg_state     (o_dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = 1;  // 0 selects a random latency of 1..3 per request

  // Instruction memory contents as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  // Wait (bounded) for a head instruction, check it, let it be consumed
  task automatic wait_head(input string tag, input logic [31:0] pc);
    int k = 0;
    while (!o_instr_valid && k < 40) begin
      step(1);
      k++;
    end
    check({tag, "_valid"}, 32'(o_instr_valid), 32'd1);
    check({tag, "_pc"}, o_pc, pc);
    check({tag, "_pc4"}, o_pc_four, pc + 32'd4);
    step(1);
  endtask

  task automatic wait_req(input int bound);
    int k = 0;
    while (!o_imem_req && k < bound) begin
      step(1);
      k++;
    end
  endtask

  // Memory responder: acks after mem_lat cycles, one request at a time
  initial begin
    int wait_cnt = 0;
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'h0;
    forever begin
      @(posedge i_clk);
      #1;
      i_imem_ack = 1'b0;
      if (o_imem_req && !i_reset) begin
        if (wait_cnt == 0) wait_cnt = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
        wait_cnt--;
        if (wait_cnt == 0) begin
          i_imem_ack   = 1'b1;
          i_imem_rdata = mem_word(o_imem_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds the PCs the buffer should contain, in program order.
  logic [31:0] exp_q[$];
  logic [31:0] m_fetch_pc  = RESET_PC;  // next address the stream needs
  bit          m_out_valid = 1'b0;      // a request is owed a response
  bit          m_out_taint = 1'b0;      // that response must be discarded
  logic [31:0] m_out_addr  = 32'h0;

  initial begin
    bit pop;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        check("rst_req",   32'(o_imem_req), 32'd0);
        check("rst_addr",  o_imem_addr, RESET_PC);
        check("rst_valid", 32'(o_instr_valid), 32'd0);
        check("rst_instr", o_instr, NOP);
        check("rst_pc",    o_pc, 32'h0);
        check("rst_pc4",   o_pc_four, 32'h0);
        exp_q.delete();
        m_fetch_pc  = RESET_PC;
        m_out_valid = 1'b0;
        m_out_taint = 1'b0;
      end else begin
        check("valid", 32'(o_instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          check("head_pc",    o_pc, exp_q[0]);
          check("head_instr", o_instr, mem_word(exp_q[0]));
          check("head_pc4",   o_pc_four, exp_q[0] + 32'd4);
        end else begin
          check("empty_instr", o_instr, NOP);
          check("empty_pc",    o_pc, 32'h0);
          check("empty_pc4",   o_pc_four, 32'h0);
        end
        check("occupancy", 32'(exp_q.size() + int'(o_imem_req) <= DEPTH), 32'd1);
        if (m_out_valid) begin
          check("req_held",    32'(o_imem_req), 32'd1);
          check("addr_stable", o_imem_addr, m_out_addr);
        end else if (o_imem_req) begin
          check("issue_addr", o_imem_addr, m_fetch_pc);
          m_out_valid = 1'b1;
          m_out_taint = 1'b0;
          m_out_addr  = m_fetch_pc;
        end
        // Effect of the coming clock edge
        pop = (exp_q.size() != 0) && i_instr_ready;
        if (i_redirect_valid) begin
          exp_q.delete();
          m_fetch_pc = {i_redirect_pc[31:2], 2'b00};
          if (m_out_valid) begin
            if (i_imem_ack) m_out_valid = 1'b0;
            else            m_out_taint = 1'b1;
          end
        end else begin
          if (pop) void'(exp_q.pop_front());
          if (m_out_valid && i_imem_ack) begin
            if (!m_out_taint) begin
              exp_q.push_back(m_out_addr);
              m_fetch_pc = m_out_addr + 32'd4;
            end
            m_out_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int k;
    #1 i_reset = 1'b1;
    step(3);
    i_reset = 1'b0;

    // Straight-line fetch with 1-cycle memory
    wait_head("seq0", 32'h0);
    wait_head("seq4", 32'h4);
    wait_head("seq8", 32'h8);

    // Decode stall fills the buffer and stops requests
    i_instr_ready = 1'b0;
    step(10);
    check("full_no_req", 32'(o_imem_req), 32'd0);
    check("full_valid",  32'(o_instr_valid), 32'd1);
    check("full_head",   o_pc, 32'hC);
    i_instr_ready = 1'b1;
    wait_head("drain_c",  32'hC);
    wait_head("drain_10", 32'h10);
    wait_head("drain_14", 32'h14);

    // Redirect while waiting on a slow response at 0x8
    i_reset = 1'b1;
    step(2);
    mem_lat = 3;
    i_reset = 1'b0;
    wait_head("slow0", 32'h0);
    wait_head("slow4", 32'h4);
    k = 0;
    while (!(o_imem_req && o_imem_addr == 32'h8) && k < 40) begin
      step(1);
      k++;
    end
    check("wait_at_8", o_imem_addr, 32'h8);
    check("no_ack_yet", 32'(i_imem_ack), 32'd0);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h100;
    step(1);
    i_redirect_valid = 1'b0;
    k = 0;
    while (!(o_imem_req && o_imem_addr != 32'h8) && k < 40) begin
      step(1);
      k++;
    end
    check("redir_req_addr", o_imem_addr, 32'h100);
    wait_head("redir_head", 32'h100);

    // Redirect coinciding with an ack, unaligned target
    mem_lat = 1;
    i_instr_ready = 1'b0;
    k = 0;
    while (!(o_instr_valid && i_imem_ack) && k < 40) begin
      step(1);
      k++;
    end
    check("pre_flush_valid", 32'(o_instr_valid), 32'd1);
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'h203;
    step(1);
    i_redirect_valid = 1'b0;
    check("flush_empty",  32'(o_instr_valid), 32'd0);
    check("flush_no_req", 32'(o_imem_req), 32'd0);
    wait_req(20);
    check("align_addr", o_imem_addr, 32'h200);
    i_instr_ready = 1'b1;
    wait_head("align_head", 32'h200);

    // PC wrap at the top of the address space
    i_redirect_valid = 1'b1;
    i_redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    i_redirect_valid = 1'b0;
    wait_head("wrap_top",  32'hFFFF_FFFC);
    wait_head("wrap_zero", 32'h0);

    // Reset pulsed in the middle of an outstanding request
    mem_lat = 3;
    wait_req(20);
    step(1);
    i_reset = 1'b1;
    #1;
    check("midrst_req",   32'(o_imem_req), 32'd0);
    check("midrst_addr",  o_imem_addr, RESET_PC);
    check("midrst_valid", 32'(o_instr_valid), 32'd0);
    check("midrst_instr", o_instr, NOP);
    check("midrst_pc",    o_pc, 32'h0);
    check("midrst_pc4",   o_pc_four, 32'h0);
    step(2);
    i_reset = 1'b0;
    wait_req(20);
    check("post_rst_addr", o_imem_addr, RESET_PC);

    // Random traffic: stalls, variable latency, occasional redirects
    mem_lat = 0;
    repeat (600) begin
      i_instr_ready    = ($urandom_range(0, 3) != 0);
      i_redirect_valid = ($urandom_range(0, 15) == 0);
      i_redirect_pc    = $urandom;
      step(1);
    end
    i_redirect_valid = 1'b0;
    i_instr_ready    = 1'b1;
    step(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
